calc_merge_2to1: RTL and testbench

- Reassembles results from the two parallel Calc lanes into one ordered stream.
- It is the return path of the 2-way dispatch demux in the calculation pipeline.
- Each dispatch event records its lane select in an order FIFO, and each lane's results are buffered in a per-lane FIFO.
- Output is released in original dispatch order through a registered valid/ready interface.

---
 rtl/calc_pkg.sv | 18 +
 rtl/calc_merge_2to1_if.sv | 56 +++++
 rtl/calc_merge_2to1_sync_fifo.sv | 80 ++++++++
 rtl/calc_merge_2to1.sv | 140 ++++++++++++++
 tb/tb_calc_merge_2to1.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared constants for the calc pipeline dispatch/merge blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package calc_pkg;

  // Lane-select encoding carried on disp_sel; the dispatch demux uses the same values.
  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  // Default datapath width of a calc lane result.
  localparam int CALC_W = 32;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/calc_merge_2to1_if.sv
// Handshake/data bundle between the two calc lanes, the dispatcher and the merge block.
// Latency: n/a (wires only).
// Backpressure: out_ready from downstream; order_full/lane*_full advise upstream.
//
// Signals:
//   disp_valid/disp_sel  dispatch strobe and the lane the operand went to
//   in0_valid/in0        lane0 result strobe and data
//   in1_valid/in1        lane1 result strobe and data
//   out_ready            downstream accepts out this cycle
//   out_valid/out        merged result stream in dispatch order
//   order_full           order FIFO full, upstream must not dispatch
//   lane0_full/lane1_full lane result FIFO full
//   overflow             sticky drop indicator
interface calc_merge_2to1_if
  import calc_pkg::*;
#(
  parameter int M = CALC_W
) ();

  logic         disp_valid;
  logic         disp_sel;
  logic         in0_valid;
  logic [M-1:0] in0;
  logic         in1_valid;
  logic [M-1:0] in1;
  logic         out_ready;
  logic         out_valid;
  logic [M-1:0] out;
  logic         order_full;
  logic         lane0_full;
  logic         lane1_full;
  logic         overflow;

  // Upstream/downstream environment side.
  modport master (
    output disp_valid, disp_sel,
    output in0_valid, in0,
    output in1_valid, in1,
    output out_ready,
    input  out_valid, out,
    input  order_full, lane0_full, lane1_full,
    input  overflow
  );

  // Merge block side.
  modport slave (
    input  disp_valid, disp_sel,
    input  in0_valid, in0,
    input  in1_valid, in1,
    input  out_ready,
    output out_valid, out,
    output order_full, lane0_full, lane1_full,
    output overflow
  );

endinterface

// File: rtl/calc_merge_2to1_sync_fifo.sv
// Synchronous FIFO with registered storage, occupancy count and drop indication.
// Latency: a push is visible at head_dat/empty one cycle later.
// Backpressure: push while full is dropped unless the same cycle also pops.
//
// Ports:
//   clk, reset_n   clock and async active-low reset (clears pointers and count)
//   push/push_dat  write request and data
//   pop            read request; ignored while empty
//   head_dat       oldest entry (valid when !empty)
//   full/empty     decoded from the registered count
//   count          current occupancy, 0..DEPTH
//   drop           push refused this cycle (full and no pop)
module sync_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok;
  logic          pop_ok;
  logic [W-1:0]  mem_q [DEPTH];

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign head_dat = mem_q[rd_ptr_q];
  assign drop     = push & ~push_ok;

  always_comb begin
    pop_ok   = pop & ~empty;
    // A pop in the same cycle frees the slot the push needs, so full only
    // refuses a push when nothing leaves.
    push_ok  = push & (~full | pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // DEPTH is a power of two, so pointer wrap is plain overflow.
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only observed once counted in.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/calc_merge_2to1.sv
// Merges the two calc lane result streams back into original dispatch order.
// Latency: lane result to out_valid is 2 cycles (FIFO write, output register).
// Backpressure: out_ready low freezes out/out_valid; FIFOs fill, then overflow flags drops.
//
// Ports:
//   clk, reset_n   clock and async active-low reset
//   bus (slave)    dispatch record, lane results, merged output and status flags
module calc_merge_2to1
  import calc_pkg::*;
#(
  parameter int M           = CALC_W,
  parameter int DEPTH       = 4,
  parameter int ORDER_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  calc_merge_2to1_if.slave    bus
);

  localparam int OCW = cnt_width(ORDER_DEPTH);
  localparam int LCW = cnt_width(DEPTH);

  // Order FIFO outputs.
  logic           ord_head;
  logic           ord_full;
  logic           ord_empty;
  logic [OCW-1:0] ord_cnt;
  logic           ord_drop;

  // Lane FIFO outputs.
  logic [M-1:0]   l0_head, l1_head;
  logic           l0_full, l1_full;
  logic           l0_empty, l1_empty;
  logic [LCW-1:0] l0_cnt, l1_cnt;
  logic           l0_drop, l1_drop;

  // Head-match pop control.
  logic           head_lane_rdy;
  logic           pop;
  logic           pop0;
  logic           pop1;

  // Output register and sticky flag.
  logic           out_valid_q, out_valid_d;
  logic [M-1:0]   out_q, out_d;
  logic           overflow_q, overflow_d;

  // Occupancy counts are kept on the FIFO for debug visibility only.
  logic           unused_cnt;
  assign unused_cnt = ^{ord_cnt, l0_cnt, l1_cnt};

  sync_fifo #(
    .W     (1),
    .DEPTH (ORDER_DEPTH)
  ) u_order_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (bus.disp_valid),
    .push_dat (bus.disp_sel),
    .pop      (pop),
    .head_dat (ord_head),
    .full     (ord_full),
    .empty    (ord_empty),
    .count    (ord_cnt),
    .drop     (ord_drop)
  );

  sync_fifo #(
    .W     (M),
    .DEPTH (DEPTH)
  ) u_lane0_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (bus.in0_valid),
    .push_dat (bus.in0),
    .pop      (pop0),
    .head_dat (l0_head),
    .full     (l0_full),
    .empty    (l0_empty),
    .count    (l0_cnt),
    .drop     (l0_drop)
  );

  sync_fifo #(
    .W     (M),
    .DEPTH (DEPTH)
  ) u_lane1_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (bus.in1_valid),
    .push_dat (bus.in1),
    .pop      (pop1),
    .head_dat (l1_head),
    .full     (l1_full),
    .empty    (l1_empty),
    .count    (l1_cnt),
    .drop     (l1_drop)
  );

  always_comb begin
    // Only the lane named by the oldest dispatch may drain; a result sitting
    // on the other lane waits, which is what restores dispatch order.
    head_lane_rdy = (ord_head == LANE0) ? ~l0_empty : ~l1_empty;
    pop           = ~ord_empty & head_lane_rdy & (~out_valid_q | bus.out_ready);
    pop0          = pop & (ord_head == LANE0);
    pop1          = pop & (ord_head == LANE1);

    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_d       = (ord_head == LANE0) ? l0_head : l1_head;
    end else if (bus.out_ready) begin
      // Consumed with nothing to replace it; data is left as-is.
      out_valid_d = 1'b0;
    end

    overflow_d = overflow_q | ord_drop | l0_drop | l1_drop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out        = out_q;
  assign bus.order_full = ord_full;
  assign bus.lane0_full = l0_full;
  assign bus.lane1_full = l1_full;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_calc_merge_2to1.sv
// Directed bench for calc_merge_2to1 with a queue-level reference model.
// Latency: n/a.
// Backpressure: exercised through out_ready and the full/overflow scenarios.
module tb_calc_merge_2to1;

  localparam int M           = 32;
  localparam int DEPTH       = 4;
  localparam int ORDER_DEPTH = 8;

  logic clk;
  logic reset_n;

  calc_merge_2to1_if #(.M(M)) bus ();

  calc_merge_2to1 #(
    .M           (M),
    .DEPTH       (DEPTH),
    .ORDER_DEPTH (ORDER_DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (queues, dispatch-order rules) ----------------
  bit          mq_ord[$];
  logic [31:0] mq_l0[$];
  logic [31:0] mq_l1[$];
  logic        m_vld = 1'b0;
  logic [31:0] m_out = '0;
  logic        m_ovf = 1'b0;
  int          cyc   = 0;
  logic [31:0] log_dat[$];   // results accepted downstream
  int          log_cyc[$];   // cycle each was accepted
  logic [31:0] exp_q[$];

  initial begin : model
    bit do_pop;
    bit lane;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mq_ord.delete();
        mq_l0.delete();
        mq_l1.delete();
        m_vld = 1'b0;
        m_out = '0;
        m_ovf = 1'b0;
      end else begin
        cyc++;
        if (m_vld && bus.out_ready) begin
          log_dat.push_back(m_out);
          log_cyc.push_back(cyc);
        end
        do_pop = 1'b0;
        lane   = 1'b0;
        if (mq_ord.size() != 0) begin
          lane   = mq_ord[0];
          do_pop = ((lane ? mq_l1.size() : mq_l0.size()) != 0) && (!m_vld || bus.out_ready);
        end
        if (do_pop) begin
          void'(mq_ord.pop_front());
          m_out = lane ? mq_l1.pop_front() : mq_l0.pop_front();
          m_vld = 1'b1;
        end else if (bus.out_ready) begin
          m_vld = 1'b0;
        end
        // Capacity is judged after this cycle's pop, so a full FIFO that
        // drains one entry still takes the new one.
        if (bus.disp_valid) begin
          if (mq_ord.size() < ORDER_DEPTH) mq_ord.push_back(bus.disp_sel);
          else m_ovf = 1'b1;
        end
        if (bus.in0_valid) begin
          if (mq_l0.size() < DEPTH) mq_l0.push_back(bus.in0);
          else m_ovf = 1'b1;
        end
        if (bus.in1_valid) begin
          if (mq_l1.size() < DEPTH) mq_l1.push_back(bus.in1);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial begin : compare
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("cyc_out_valid",  bus.out_valid,  m_vld);
      chk("cyc_out",        bus.out,        m_out);
      chk("cyc_order_full", bus.order_full, mq_ord.size() == ORDER_DEPTH);
      chk("cyc_lane0_full", bus.lane0_full, mq_l0.size() == DEPTH);
      chk("cyc_lane1_full", bus.lane1_full, mq_l1.size() == DEPTH);
      chk("cyc_overflow",   bus.overflow,   m_ovf);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit dv, input bit ds, input bit v0, input logic [31:0] d0,
                      input bit v1, input logic [31:0] d1, input bit rdy);
    @(negedge clk);
    bus.disp_valid = dv;
    bus.disp_sel   = ds;
    bus.in0_valid  = v0;
    bus.in0        = d0;
    bus.in1_valid  = v1;
    bus.in1        = d1;
    bus.out_ready  = rdy;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, rdy);
  endtask

  // Reset asserted away from the clock edge, held two cycles.
  task automatic reset_pulse();
    @(negedge clk);
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Compare accepted results with exp_q; optionally require back-to-back cycles.
  task automatic check_log(input string name, input bit consec);
    chk({name, "_count"}, log_dat.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < log_dat.size()) begin
        chk($sformatf("%s_dat%0d", name, i), log_dat[i], exp_q[i]);
        if (consec && i > 0) chk($sformatf("%s_gap%0d", name, i), log_cyc[i] - log_cyc[i-1], 1);
      end
    end
    log_dat.delete();
    log_cyc.delete();
  endtask

  // Dispatch 0,1,0,1; each result returns 3 cycles after its dispatch.
  task automatic run_inorder(input string name);
    step(1, 0, 0, '0,    0, '0,    1);
    step(1, 1, 0, '0,    0, '0,    1);
    step(1, 0, 0, '0,    0, '0,    1);
    step(1, 1, 1, 'h11,  0, '0,    1);
    step(0, 0, 0, '0,    1, 'h22,  1);
    step(0, 0, 1, 'h33,  0, '0,    1);
    step(0, 0, 0, '0,    1, 'h44,  1);
    idle(6, 1);
    exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    check_log(name, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    reset_n        = 1'b0;
    bus.disp_valid = 1'b0;
    bus.disp_sel   = 1'b0;
    bus.in0_valid  = 1'b0;
    bus.in0        = '0;
    bus.in1_valid  = 1'b0;
    bus.in1        = '0;
    bus.out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid",  bus.out_valid,  0);
    chk("rst_out",        bus.out,        0);
    chk("rst_order_full", bus.order_full, 0);
    chk("rst_lane0_full", bus.lane0_full, 0);
    chk("rst_lane1_full", bus.lane1_full, 0);
    chk("rst_overflow",   bus.overflow,   0);
    reset_n = 1'b1;
    log_dat.delete();
    log_cyc.delete();

    // In-order return.
    run_inorder("inorder");

    // Reordering: lane1 result arrives 4 cycles ahead of the older lane0 one.
    step(1, 0, 0, '0,      0, '0,      1);
    step(1, 1, 0, '0,      1, 'hBEEF,  1);
    idle(3, 1);
    chk("reord_wait_valid", bus.out_valid, 0);
    step(0, 0, 1, 'hCAFE,  0, '0,      1);
    chk("reord_wait_valid2", bus.out_valid, 0);
    idle(5, 1);
    exp_q = '{32'hCAFE, 32'hBEEF};
    check_log("reord", 1'b1);

    // Backpressure: three results queued, out_ready low for 5 cycles.
    step(1, 0, 1, 'hA1, 0, '0, 0);
    step(1, 0, 1, 'hA2, 0, '0, 0);
    step(1, 0, 1, 'hA3, 0, '0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, '0, 0, '0, 0);
      chk($sformatf("bp_hold_valid%0d", i), bus.out_valid, 1);
      chk($sformatf("bp_hold_out%0d", i),   bus.out,       'hA1);
    end
    idle(6, 1);
    exp_q = '{32'hA1, 32'hA2, 32'hA3};
    check_log("bp", 1'b1);

    // Full/overflow: five lane0 results, no dispatch so nothing drains.
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 32'hD0 + i, 0, '0, 0);
    step(0, 0, 1, 'hD5, 0, '0, 0);
    chk("ovf_full_after4", bus.lane0_full, 1);
    chk("ovf_clear_after4", bus.overflow, 0);
    step(0, 0, 0, '0, 0, '0, 0);
    chk("ovf_set", bus.overflow, 1);
    chk("ovf_full_kept", bus.lane0_full, 1);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, '0, 0, '0, 0);
      chk($sformatf("ovf_sticky%0d", i), bus.overflow, 1);
    end
    chk("ovf_no_out", bus.out_valid, 0);
    reset_pulse();
    chk("ovf_rst_clear", bus.overflow, 0);
    chk("ovf_rst_full", bus.lane0_full, 0);
    log_dat.delete();
    log_cyc.delete();

    // Push into a full lane0 on the same cycle it pops.
    for (int i = 1; i <= 5; i++) step(1, 0, 1, 32'hB0 + i, 0, '0, 0);
    step(1, 0, 1, 'hB6, 0, '0, 1);
    chk("pp_full_before", bus.lane0_full, 1);
    step(0, 0, 0, '0, 0, '0, 1);
    chk("pp_full_after", bus.lane0_full, 1);
    chk("pp_no_ovf", bus.overflow, 0);
    idle(7, 1);
    exp_q = '{32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6};
    check_log("pp", 1'b1);

    // Async reset with entries buffered, then a clean in-order run.
    step(1, 0, 1, 'hC1, 0, '0, 0);
    step(1, 0, 1, 'hC2, 0, '0, 0);
    step(1, 0, 1, 'hC3, 0, '0, 0);
    step(0, 0, 0, '0,   0, '0, 0);
    chk("mr_pre_valid", bus.out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_out_valid", bus.out_valid, 0);
    chk("mr_out",       bus.out,       0);
    chk("mr_lane0_full", bus.lane0_full, 0);
    chk("mr_overflow",  bus.overflow,  0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("mr_order_full", bus.order_full, 0);
    chk("mr_lane1_full", bus.lane1_full, 0);
    log_dat.delete();
    log_cyc.delete();
    run_inorder("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
